// File: rtl/histo_bin_ctrl_pkg.sv
// histo_pkg: shared types and default sizes for the histogram bin controller.
// Optional build macro: HISTO_SAT_EN (saturating bin counters, see histo_inc).
package histo_pkg;

    localparam int HISTO_ADDR_W   = 10;
    localparam int HISTO_DATA_W   = 32;
    localparam int HISTO_NUM_BINS = 1 << HISTO_ADDR_W;

    typedef enum logic [2:0] {
        INIT_CLR = 3'd0,
        ACCUM    = 3'd1,
        DRAIN    = 3'd2,
        SW_RD    = 3'd3,
        SW_OUT   = 3'd4
    } histo_state_t;

endpackage

// File: rtl/histo_bin_ctrl_if.sv
// Pixel input and readout handshake bundle of the histogram bin controller.
// The master side is the environment (binning stage + readout consumer),
// the slave side is histo_bin_ctrl. Optional build macro: HISTO_SAT_EN.
interface histo_bin_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              pix_valid;
    logic [ADDR_W-1:0] pix_bin;
    logic              pix_ready;
    logic              frame_end;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_bin;
    logic [DATA_W-1:0] rd_count;
    logic              rd_ready;
    logic              frame_done;
    logic              busy;

    modport master (
        output pix_valid, pix_bin, frame_end, rd_ready,
        input  pix_ready, rd_valid, rd_bin, rd_count, frame_done, busy
    );

    modport slave (
        input  pix_valid, pix_bin, frame_end, rd_ready,
        output pix_ready, rd_valid, rd_bin, rd_count, frame_done, busy
    );
endinterface

// File: rtl/histo_bin_ctrl_inc.sv
// histo_inc: forward-select of the increment base plus the bin increment.
// Build macro HISTO_SAT_EN: defined -> saturate at all-ones, undefined -> wrap.
module histo_inc #(
    parameter int DATA_W = 32
) (
    input  logic              fwd_i,
    input  logic [DATA_W-1:0] fwd_data_i,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] base;

    // Pick the forwarded value when the RAM read raced the previous write.
    always_comb begin
        base = fwd_i ? fwd_data_i : ram_data_i;
`ifdef HISTO_SAT_EN
        sum_o = (&base) ? base : base + DATA_W'(1);
`else
        sum_o = base + DATA_W'(1);
`endif
    end

endmodule

// File: rtl/histo_bin_ctrl.sv
// histo_bin_ctrl: read-modify-write controller for the histogram bin RAM.
// Clears all bins after reset, increments one bin per accepted pixel with
// same-bin forwarding, and on frame end sweeps every bin out through the
// readout handshake, zeroing each bin once it is accepted.
// Optional build macro: HISTO_SAT_EN (saturating counters instead of wrap).
module histo_bin_ctrl
    import histo_pkg::*;
#(
    parameter int ADDR_W = HISTO_ADDR_W,
    parameter int DATA_W = HISTO_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    histo_bin_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata
);

    localparam logic [ADDR_W-1:0] LAST_BIN = '1;

    histo_state_t      state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              done_q, done_d;
    logic              s1_vld_q;
    logic [ADDR_W-1:0] s1_bin_q;
    logic              fwd_hit_q;
    logic [DATA_W-1:0] wdata_q;
    logic              sw_first_q;
    logic [DATA_W-1:0] rd_hold_q;

    logic              accept;
    logic              rd_fire;
    logic              fwd_hit_d;
    logic [DATA_W-1:0] inc_val;
    logic [DATA_W-1:0] rd_cnt;

    assign accept    = (state_q == ACCUM) && bus.pix_valid && !reset;
    assign rd_fire   = (state_q == SW_OUT) && bus.rd_ready && !reset;
    // The RAM returns the old value when read and written on the same edge,
    // so a back-to-back pixel on the same bin must take the in-flight value.
    assign fwd_hit_d = accept && s1_vld_q && (s1_bin_q == bus.pix_bin);

    histo_inc #(.DATA_W(DATA_W)) u_inc (
        .fwd_i      (fwd_hit_q),
        .fwd_data_i (wdata_q),
        .ram_data_i (ram_rdata),
        .sum_o      (inc_val)
    );

    // Control state: FSM, bin counter, stage-1 valid, forward flag, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT_CLR;
            k_q        <= '0;
            done_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            fwd_hit_q  <= 1'b0;
            sw_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            done_q     <= done_d;
            s1_vld_q   <= accept;
            fwd_hit_q  <= fwd_hit_d;
            sw_first_q <= (state_q == SW_RD);
        end
    end

    // Datapath registers: stage-1 bin, last written value, held readout count.
    always_ff @(posedge clk) begin
        s1_bin_q  <= bus.pix_bin;
        wdata_q   <= ram_wdata;
        rd_hold_q <= rd_cnt;
    end

    // Next-state logic for the sequencer and shared bin counter.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        done_d  = 1'b0;
        case (state_q)
            INIT_CLR: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST_BIN) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.frame_end) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Stage 1 never refills here, so one cycle empties it.
                state_d = SW_RD;
                k_d     = '0;
            end
            SW_RD: begin
                state_d = SW_OUT;
            end
            SW_OUT: begin
                if (rd_fire) begin
                    if (k_q == LAST_BIN) begin
                        done_d  = 1'b1;
                        state_d = ACCUM;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = SW_RD;
                    end
                end
            end
            default: begin
                state_d = INIT_CLR;
                k_d     = '0;
            end
        endcase
    end

    // RAM port and handshake outputs; all quiet while reset is asserted.
    always_comb begin
        ram_raddr     = '0;
        ram_we        = 1'b0;
        ram_waddr     = '0;
        ram_wdata     = '0;
        bus.pix_ready = 1'b0;
        bus.rd_valid  = 1'b0;
        if (!reset) begin
            case (state_q)
                INIT_CLR: begin
                    ram_we    = 1'b1;
                    ram_waddr = k_q;
                end
                ACCUM: begin
                    bus.pix_ready = 1'b1;
                    ram_raddr     = bus.pix_bin;
                    if (s1_vld_q) begin
                        ram_we    = 1'b1;
                        ram_waddr = s1_bin_q;
                        ram_wdata = inc_val;
                    end
                end
                DRAIN: begin
                    if (s1_vld_q) begin
                        ram_we    = 1'b1;
                        ram_waddr = s1_bin_q;
                        ram_wdata = inc_val;
                    end
                end
                SW_RD: begin
                    ram_raddr = k_q;
                end
                SW_OUT: begin
                    ram_raddr    = k_q;
                    bus.rd_valid = 1'b1;
                    if (rd_fire) begin
                        ram_we    = 1'b1;
                        ram_waddr = k_q;
                    end
                end
                default: begin
                    ram_we = 1'b0;
                end
            endcase
        end
    end

    assign rd_cnt         = sw_first_q ? ram_rdata : rd_hold_q;
    assign bus.rd_count   = rd_cnt;
    assign bus.rd_bin     = k_q;
    assign bus.frame_done = done_q && !reset;
    assign bus.busy       = reset || (state_q != ACCUM);

endmodule

// File: tb/tb_histo_bin_ctrl.sv
// Testbench for histo_bin_ctrl with a behavioural dual-port RAM beside it.
// Optional build macro: HISTO_SAT_EN (changes the expected counter limit).
module tb_histo_bin_ctrl;
    import histo_pkg::*;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int NB  = 1 << AW;
    localparam int AW2 = 2;
    localparam int DW2 = 4;
    localparam int NB2 = 1 << AW2;

    typedef struct packed {
        logic [AW-1:0] bin;
        logic [DW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset2;

    histo_bin_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    histo_bin_ctrl_if #(.ADDR_W(AW2), .DATA_W(DW2)) bus2 ();

    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [DW-1:0] ram_rdata, ram_wdata;
    logic          ram_we;
    logic [AW2-1:0] ram2_raddr, ram2_waddr;
    logic [DW2-1:0] ram2_rdata, ram2_wdata;
    logic           ram2_we;

    histo_bin_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata)
    );

    histo_bin_ctrl #(.ADDR_W(AW2), .DATA_W(DW2)) dut2 (
        .clk       (clk),
        .reset     (reset2),
        .bus       (bus2),
        .ram_raddr (ram2_raddr),
        .ram_rdata (ram2_rdata),
        .ram_we    (ram2_we),
        .ram_waddr (ram2_waddr),
        .ram_wdata (ram2_wdata)
    );

    // Dual-port RAM models: registered read, old data on read-during-write.
    logic [DW-1:0]  mem  [NB];
    logic [DW2-1:0] mem2 [NB2];
    always @(posedge clk) begin
        ram_rdata  <= mem[ram_raddr];
        ram2_rdata <= mem2[ram2_raddr];
        if (ram_we)  mem[ram_waddr]   <= ram_wdata;
        if (ram2_we) mem2[ram2_waddr] <= ram2_wdata;
    end

    int unsigned model_h [NB];
    exp_t        sb [$];
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    task automatic build_sb();
        exp_t e;
        sb.delete();
        for (int i = 0; i < NB; i++) begin
            e.bin = AW'(i);
            e.cnt = DW'(model_h[i]);
            sb.push_back(e);
            model_h[i] = 0;
        end
    endtask

    task automatic wait_ready(input int expect_cycles);
        int n = 0;
        while (!bus.pix_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (!bus.pix_ready) $display("FAIL init_timeout: pix_ready still %0b after %0d cycles, need 1", bus.pix_ready, n);
        else if (expect_cycles >= 0 && n != expect_cycles)
            $display("FAIL init_len: pix_ready rose after %0d cycles, need %0d", n, expect_cycles);
        else pass_cnt++;
    endtask

    task automatic drive_pixel(input int b);
        chk_cnt++;
        if (bus.pix_ready !== 1'b1) $display("FAIL pix_ready: got %0b need 1 (bin %0d)", bus.pix_ready, b);
        else pass_cnt++;
        bus.pix_valid = 1'b1;
        bus.pix_bin   = AW'(b);
        @(negedge clk);
        model_h[b] = model_h[b] + 1;
        bus.pix_valid = 1'b0;
    endtask

    // Raise frame_end (optionally with a last pixel on the same edge) and
    // consume the sweep; abort_bin >= 0 stops before accepting that bin.
    task automatic end_frame_readout(input bit rand_rdy, input int last_pix, input int abort_bin);
        int  cyc   = 1;
        int  dones = 0;
        bit  seen  = 0;
        bit  rdy;
        bus.frame_end = 1'b1;
        if (last_pix >= 0) begin
            bus.pix_valid = 1'b1;
            bus.pix_bin   = AW'(last_pix);
        end
        @(negedge clk);
        if (last_pix >= 0) model_h[last_pix] = model_h[last_pix] + 1;
        bus.frame_end = 1'b0;
        bus.pix_valid = 1'b0;
        build_sb();
        chk_cnt++;
        if (bus.pix_ready !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL drain_state: pix_ready=%0b busy=%0b, need 0/1", bus.pix_ready, bus.busy);
        else pass_cnt++;
        while (sb.size() > 0 && cyc < 5 * NB + 20) begin
            if (bus.frame_done) dones++;
            if (bus.rd_valid) begin
                if (!seen) begin
                    seen = 1;
                    chk_cnt++;
                    if (cyc != 3) $display("FAIL rd_latency: first rd_valid after %0d cycles, need 3", cyc);
                    else pass_cnt++;
                end
                chk_cnt++;
                if (bus.rd_bin !== sb[0].bin || bus.rd_count !== sb[0].cnt)
                    $display("FAIL readout: bin %0d count %0d, need bin %0d count %0d",
                             bus.rd_bin, bus.rd_count, sb[0].bin, sb[0].cnt);
                else pass_cnt++;
                if (abort_bin >= 0 && int'(bus.rd_bin) == abort_bin) begin
                    bus.rd_ready = 1'b0;
                    return;
                end
                rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.rd_ready = rdy;
                if (rdy) void'(sb.pop_front());
            end else begin
                bus.rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.rd_ready = 1'b0;
        chk_cnt++;
        if (sb.size() != 0) $display("FAIL sweep_timeout: %0d words left, need 0", sb.size());
        else pass_cnt++;
        chk_cnt++;
        if (bus.frame_done !== 1'b1 || bus.pix_ready !== 1'b1 || dones != 0)
            $display("FAIL frame_done: done=%0b pix_ready=%0b early_pulses=%0d, need 1/1/0",
                     bus.frame_done, bus.pix_ready, dones);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus.frame_done !== 1'b0) $display("FAIL done_pulse: frame_done=%0b one cycle later, need 0", bus.frame_done);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (bus.pix_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.frame_done !== 1'b0 ||
            ram_we !== 1'b0 || bus.busy !== 1'b1 || ram_raddr !== '0 || ram_waddr !== '0)
            $display("FAIL reset_vals: rdy=%0b vld=%0b done=%0b we=%0b busy=%0b raddr=%0d waddr=%0d",
                     bus.pix_ready, bus.rd_valid, bus.frame_done, ram_we, bus.busy, ram_raddr, ram_waddr);
        else pass_cnt++;
        reset  = 1'b0;
        reset2 = 1'b0;
        wait_ready(NB);
        end_frame_readout(1'b0, -1, -1);
    endtask

    task automatic test_same_bin();
        for (int i = 0; i < 5; i++) drive_pixel(7);
        end_frame_readout(1'b0, -1, -1);
    endtask

    task automatic test_mixed();
        drive_pixel(3);
        drive_pixel(4);
        drive_pixel(3);
        drive_pixel(3);
        end_frame_readout(1'b0, 4, -1);
        end_frame_readout(1'b0, -1, -1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 24; i++) drive_pixel(int'($urandom_range(0, 15)));
        drive_pixel(NB - 1);
        drive_pixel(NB - 1);
        end_frame_readout(1'b1, 0, -1);
    endtask

    task automatic test_reset_mid_sweep();
        drive_pixel(500);
        drive_pixel(12);
        end_frame_readout(1'b0, -1, 500);
        reset = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (bus.rd_valid !== 1'b0 || bus.pix_ready !== 1'b0 || ram_we !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL mid_reset: vld=%0b rdy=%0b we=%0b busy=%0b, need 0/0/0/1",
                     bus.rd_valid, bus.pix_ready, ram_we, bus.busy);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < NB; i++) model_h[i] = 0;
        wait_ready(NB);
        drive_pixel(500);
        end_frame_readout(1'b0, -1, -1);
    endtask

    task automatic test_counter_limit();
        int unsigned exp_v = 0;
        int          got   = 0;
        int          n     = 0;
        while (!bus2.pix_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 17; i++) begin
`ifdef HISTO_SAT_EN
            exp_v = (exp_v == 15) ? 15 : exp_v + 1;
`else
            exp_v = (exp_v + 1) % 16;
`endif
            bus2.pix_valid = 1'b1;
            bus2.pix_bin   = '0;
            @(negedge clk);
        end
        bus2.pix_valid = 1'b0;
        bus2.frame_end = 1'b1;
        @(negedge clk);
        bus2.frame_end = 1'b0;
        bus2.rd_ready  = 1'b1;
        n = 0;
        while (got < NB2 && n < 40) begin
            if (bus2.rd_valid) begin
                chk_cnt++;
                if (int'(bus2.rd_bin) != got || int'(bus2.rd_count) != ((got == 0) ? int'(exp_v) : 0))
                    $display("FAIL counter_limit: bin %0d count %0d, need bin %0d count %0d",
                             bus2.rd_bin, bus2.rd_count, got, (got == 0) ? int'(exp_v) : 0);
                else pass_cnt++;
                got++;
            end
            @(negedge clk);
            n++;
        end
        bus2.rd_ready = 1'b0;
        chk_cnt++;
        if (got != NB2) $display("FAIL counter_sweep: %0d words read, need %0d", got, NB2);
        else pass_cnt++;
    endtask

    initial begin
        reset          = 1'b1;
        reset2         = 1'b1;
        bus.pix_valid  = 1'b0;
        bus.pix_bin    = '0;
        bus.frame_end  = 1'b0;
        bus.rd_ready   = 1'b0;
        bus2.pix_valid = 1'b0;
        bus2.pix_bin   = '0;
        bus2.frame_end = 1'b0;
        bus2.rd_ready  = 1'b0;
        for (int i = 0; i < NB; i++) model_h[i] = 0;

        test_reset();
        test_same_bin();
        test_mixed();
        test_backpressure();
        test_counter_limit();
        test_reset_mid_sweep();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
